// File: rtl/instr_assembler.sv
// instr_assembler: packs decoded RV32I fields into instruction words and writes them to memory sequentially.
// Optional build macro ASM_RANGE_CHECK_EN rejects immediates that do not fit their format instead of truncating them.
module instr_assembler #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_FMT   = 2'd2;

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t          state, state_nxt;
    logic            accept;
    logic            fmt_bad;
    logic            range_bad;
    logic            bundle_ok;
    logic [ADDR_W:0] count_inc;

    function automatic logic [31:0] encode(
        input logic [2:0]  f,
        input logic [6:0]  op,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] v
    );
        logic [31:0] w;
        w = 32'd0;
        case (f)
            FMT_R:   w = {f7, s2, s1, f3, d, op};
            FMT_I:   w = {v[11:0], s1, f3, d, op};
            FMT_S:   w = {v[11:5], s2, s1, f3, v[4:0], op};
            FMT_B:   w = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
            FMT_U:   w = {v[31:12], d, op};
            FMT_J:   w = {v[20], v[10:1], v[11], v[19:12], d, op};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

`ifdef ASM_RANGE_CHECK_EN
    // An immediate fits when every bit above its top encodable bit repeats that sign bit.
    function automatic logic imm_fits(input logic [2:0] f, input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        case (f)
            FMT_I, FMT_S: ok = (v[31:11] == {21{v[11]}});
            FMT_B:        ok = (v[31:12] == {20{v[12]}}) && !v[0];
            FMT_J:        ok = (v[31:20] == {12{v[20]}}) && !v[0];
            FMT_U:        ok = (v[11:0] == 12'd0);
            default:      ok = 1'b1;
        endcase
        return ok;
    endfunction

    assign range_bad = !fmt_bad && !imm_fits(fmt, imm);
`else
    assign range_bad = 1'b0;
`endif

    assign fmt_bad   = (fmt > FMT_J);
    assign bundle_ok = !fmt_bad && !range_bad;
    assign in_ready  = rst_n && (state == IDLE) && !start;
    assign accept    = in_valid && in_ready;
    assign mem_we    = (state == WRITE);
    assign count_inc = count + (ADDR_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && bundle_ok) state_nxt = WRITE;
            WRITE:   if (mem_ack) state_nxt = (count_inc == DEPTH) ? FULL : IDLE;
            FULL:    if (start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // start is ignored mid-write so a memory transaction is never abandoned half way.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr  <= BASE;
            mem_wdata <= 32'd0;
            count     <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else if (start && state != WRITE) begin
            mem_addr <= BASE;
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (accept) begin
                if (fmt_bad) begin
                    err      <= 1'b1;
                    err_code <= ERR_FMT;
                end else if (range_bad) begin
                    err      <= 1'b1;
                    err_code <= ERR_RANGE;
                end else begin
                    mem_wdata <= encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
                end
            end
            if (state == WRITE && mem_ack) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                count    <= count_inc;
            end
        end
    end

endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler: known-word table, error and stall sequences, small-memory wrap, and a
// randomized run checked by decoding each written word back to its fields and immediate.
module tb_instr_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, in_valid, mem_ack;
    logic [2:0]  fmt, funct3;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;

    logic        in_ready, mem_we, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [10:0] count;
    logic [1:0]  err_code;

    logic        in_ready_s, mem_we_s, err_s;
    logic [1:0]  mem_addr_s;
    logic [31:0] mem_wdata_s;
    logic [2:0]  count_s;
    logic [1:0]  err_code_s;

    instr_assembler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .count(count), .err(err), .err_code(err_code)
    );

    instr_assembler #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
        .mem_wdata(mem_wdata_s), .mem_ack(mem_ack), .count(count_s), .err(err_s),
        .err_code(err_code_s)
    );

    typedef struct {
        logic [2:0]  f;
        logic [6:0]  op;
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] v;
        logic [31:0] word;
    } vec_t;

    vec_t tbl[8];

    int checks = 0;
    int errors = 0;

    logic        cap_we, cap_we_s;
    logic [9:0]  cap_addr;
    logic [1:0]  cap_addr_s;
    logic [31:0] cap_word, cap_word_s;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Immediate generator model: recovers the immediate from an instruction word.
    function automatic int imm_gen(input int f, input logic [31:0] w);
        int x;
        x = int'(w);
        case (f)
            1: return x >>> 20;
            2: return (x >>> 25) * 32 + int'((w >> 7) & 32'd31);
            3: return (x >>> 31) * 4096 + int'((w >> 7) & 32'd1) * 2048
                      + int'((w >> 25) & 32'd63) * 32 + int'((w >> 8) & 32'd15) * 2;
            4: return int'(w & 32'hFFFFF000);
            5: return (x >>> 31) * 1048576 + int'((w >> 12) & 32'd255) * 4096
                      + int'((w >> 20) & 32'd1) * 2048 + int'((w >> 21) & 32'd1023) * 2;
            default: return 0;
        endcase
    endfunction

    // Immediate that survives encoding: the value reduced to the format's range and alignment.
    function automatic int exp_imm(input int f, input int v);
        int t;
        case (f)
            1, 2: begin t = v & 4095; if (t >= 2048) t -= 4096; end
            3: begin t = v & 8191; if (t >= 4096) t -= 8192; t = t & -2; end
            5: begin t = v & 2097151; if (t >= 1048576) t -= 2097152; t = t & -2; end
            4: t = v & int'(32'hFFFFF000);
            default: t = 0;
        endcase
        return t;
    endfunction

`ifdef ASM_RANGE_CHECK_EN
    function automatic bit fits(input int f, input int v);
        case (f)
            1, 2: return v >= -2048 && v <= 2047;
            3: return v >= -4096 && v <= 4095 && (v % 2) == 0;
            4: return (v % 4096) == 0;
            5: return v >= -1048576 && v <= 1048575 && (v % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction
`endif

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] v);
        int n;
        @(posedge clk); #1;
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = v;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        cap_we = mem_we; cap_addr = mem_addr; cap_word = mem_wdata;
        cap_we_s = mem_we_s; cap_addr_s = mem_addr_s; cap_word_s = mem_wdata_s;
        if (cap_we && mem_ack) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_code"}, err_code, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_addr, exp_cnt, exp_err, exp_code, prev_cnt;
        logic [31:0] w0;
        logic [9:0]  a0;

        tbl[0] = '{3'd1, 7'h13, 5'd5,  5'd10, 5'd0, 3'd0, 7'h00, 32'd10,         32'h00A50293};
        tbl[1] = '{3'd2, 7'h23, 5'd0,  5'd3,  5'd5, 3'd2, 7'h00, 32'd12,         32'h0051A623};
        tbl[2] = '{3'd3, 7'h63, 5'd0,  5'd1,  5'd2, 3'd0, 7'h00, 32'd8,          32'h00208463};
        tbl[3] = '{3'd4, 7'h37, 5'd10, 5'd0,  5'd0, 3'd0, 7'h00, 32'h12345000,   32'h12345537};
        tbl[4] = '{3'd5, 7'h6F, 5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'd16,         32'h0100006F};
        tbl[5] = '{3'd0, 7'h33, 5'd3,  5'd1,  5'd2, 3'd0, 7'h00, 32'd0,          32'h002081B3};
        tbl[6] = '{3'd0, 7'h33, 5'd3,  5'd1,  5'd2, 3'd0, 7'h20, 32'd0,          32'h402081B3};
        tbl[7] = '{3'd3, 7'h63, 5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'hFFFFFFFC,   32'hFE000EE3};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ack = 1'b1;
        fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;

        @(negedge clk);
        chk("in_ready_in_reset", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");

        // Known encodings, written to consecutive addresses.
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].f, tbl[i].op, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].f3, tbl[i].f7, tbl[i].v);
            chk("tbl_we", cap_we, 1);
            chk("tbl_addr", cap_addr, i);
            chk("tbl_word", cap_word, tbl[i].word);
            if (tbl[i].f != 3'd0) chk("tbl_imm_roundtrip", imm_gen(tbl[i].f, cap_word), tbl[i].v);
            chk("tbl_count", count, i + 1);
        end
        exp_addr = 8;

`ifdef ASM_RANGE_CHECK_EN
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd7);
        chk("b_odd_we", cap_we, 0);
        chk("b_odd_err", err, 1);
        chk("b_odd_code", err_code, 1);
        chk("b_odd_addr", cap_addr, exp_addr);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);
        chk("i_2048_we", cap_we, 0);
        chk("i_2048_err", err, 1);
        chk("i_2048_code", err_code, 1);
        chk("i_2048_addr", cap_addr, exp_addr);
`else
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd7);
        chk("b_trunc_we", cap_we, 1);
        chk("b_trunc_imm", imm_gen(3, cap_word), 6);
        chk("b_trunc_err", err, 0);
        exp_addr++;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048);
        chk("i_trunc_we", cap_we, 1);
        chk("i_trunc_imm", imm_gen(1, cap_word), -2048);
        chk("i_trunc_err", err, 0);
        exp_addr++;
`endif
        send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0);
        chk("fmt6_we", cap_we, 0);
        chk("fmt6_err", err, 1);
        chk("fmt6_code", err_code, 2);
        chk("fmt6_addr", cap_addr, exp_addr);

        // Stalled write with a start pulse that must be ignored.
        prev_cnt = count;
        mem_ack = 1'b0;
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFF8);
        chk("stall_we0", cap_we, 1);
        chk("stall_word", cap_word, 32'hFF9FF0EF);
        w0 = cap_word; a0 = cap_addr;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            start = (k == 0);
            @(negedge clk);
            chk("stall_we", mem_we, 1);
            chk("stall_addr", mem_addr, a0);
            chk("stall_wdata", mem_wdata, w0);
            chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        chk("stall_still_write", mem_we, 1);
        @(posedge clk); #1;
        chk("stall_count", count, prev_cnt + 1);
        chk("stall_addr_inc", mem_addr, a0 + 1);
        chk("stall_err_kept", err, 1);
        @(negedge clk);
        chk("stall_we_done", mem_we, 0);

        // Reset pulse in the middle of a write.
        mem_ack = 1'b0;
        send(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'h00, 32'd5);
        chk("rst_mid_we_before", cap_we, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        check_reset_values("rst_mid");

        // Four-entry memory fills, reports FULL, then restarts on start.
        for (int i = 0; i < 4; i++) begin
            send(tbl[i].f, tbl[i].op, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].f3, tbl[i].f7, tbl[i].v);
            chk("small_we", cap_we_s, 1);
            chk("small_addr", cap_addr_s, i);
            chk("small_word", cap_word_s, tbl[i].word);
        end
        @(negedge clk);
        chk("small_full_ready", in_ready_s, 0);
        chk("small_full_count", count_s, 4);
        chk("small_full_addr", mem_addr_s, 0);
        chk("small_full_we", mem_we_s, 0);
        chk("big_not_full_ready", in_ready, 1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("small_start_addr", mem_addr_s, 0);
        chk("small_start_count", count_s, 0);
        chk("small_start_ready", in_ready_s, 1);
        chk("small_start_err", {err_s, err_code_s}, 0);
        chk("big_start_count", count, 0);

        // Randomized bundles against the reference model.
        exp_addr = 0; exp_cnt = 0; exp_err = 0; exp_code = 0;
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  f;
            logic [31:0] v;
            bit legal;
            f = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: v = (32'($urandom_range(0, 4194303)) - 32'd2097152) & ~32'd1;
                default: v = $urandom & 32'hFFFFF000;
            endcase
            legal = (f <= 3'd5);
`ifdef ASM_RANGE_CHECK_EN
            if (legal && f != 3'd0) legal = fits(int'(f), int'(v));
`endif
            send(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), v);
            if (legal) begin
                chk("rnd_we", cap_we, 1);
                chk("rnd_addr", cap_addr, exp_addr);
                chk("rnd_opcode", cap_word[6:0], opcode);
                if (f != 3'd0) chk("rnd_imm", imm_gen(int'(f), cap_word), exp_imm(int'(f), int'(v)));
                if (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd5) chk("rnd_rd", cap_word[11:7], rd);
                if (f <= 3'd3) begin
                    chk("rnd_rs1", cap_word[19:15], rs1);
                    chk("rnd_funct3", cap_word[14:12], funct3);
                end
                if (f == 3'd0 || f == 3'd2 || f == 3'd3) chk("rnd_rs2", cap_word[24:20], rs2);
                if (f == 3'd0) chk("rnd_funct7", cap_word[31:25], funct7);
                exp_addr = (exp_addr + 1) % 1024;
                exp_cnt++;
            end else begin
                chk("rnd_rej_we", cap_we, 0);
                chk("rnd_rej_addr", cap_addr, exp_addr);
                exp_err = 1;
                exp_code = (f > 3'd5) ? 2 : 1;
            end
            chk("rnd_count", count, exp_cnt);
            chk("rnd_err", {err, err_code}, {exp_err[0], exp_code[1:0]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_assembler.md
# instr_assembler

Encoding-side counterpart of the immediate generator. It accepts decoded instruction fields (format, opcode, registers, funct bits, and a full 32-bit immediate) over a valid/ready handshake. It packs them into a legal RV32I instruction word and writes the words sequentially into instruction memory through a single write port with acknowledge. It is used to load test programs and self-modifying sequences, and it guarantees that feeding its output word to the immediate generator returns the original immediate for every accepted, legal input.

## Interface
- ADDR_W, 10, word-address width of instruction memory
- BASE_ADDR, 0, first word address written after reset/start
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  pulse: restart program load at BASE_ADDR, clear count and error
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle this cycle
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6, 7 illegal
- opcode  in  7  instruction[6:0]
- rd, rs1, rs2  in  5 each  register indices (unused fields ignored per format)
- funct3  in  3; funct7  in  7  (funct7 used by R only)
- imm  in  32  immediate value in the same form the immediate generator outputs (sign-extended; U already shifted left by 12)
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ack  in  1  memory accepted the write this cycle
- count  out  ADDR_W+1  words written since reset/start
- err  out  1  sticky: at least one bundle rejected
- err_code  out  2  last rejection cause: 0 none, 1 immediate out of range, 2 illegal fmt

## Operation
- States: IDLE, WRITE, FULL.
- IDLE: in_ready = !start. Acceptance occurs on in_valid & in_ready. For a legal bundle, the encoded word is registered into mem_wdata and the state goes to WRITE. For an illegal bundle, the handshake still completes, no write occurs, the state stays IDLE, err is set to 1, and err_code is updated.
- WRITE: mem_we = 1. mem_addr and mem_wdata are held stable until mem_ack. On the mem_ack edge, mem_addr and count increment. The next state is FULL if count reaches 2^ADDR_W, otherwise IDLE.
- FULL: in_ready = 0. mem_addr stays at its wrapped value.
- start while in IDLE or FULL: mem_addr = BASE_ADDR, count = 0, err = 0, err_code = 0, next state IDLE. start during WRITE is ignored; the write completes normally.
- Encoding rules: standard RV32I bit placement. I: imm[11:0] → [31:20]. S: imm[11:5] → [31:25], imm[4:0] → [11:7]. B: imm[12|10:5|4:1|11]. U: imm[31:12]. J: imm[20|10:1|11|19:12].
- Range rules (only when the configuration macro below is defined):
  - I and S: imm equals the sign-extension of imm[11:0].
  - B: imm equals the sign-extension of imm[12:0], and imm[0] = 0.
  - J: imm equals the sign-extension of imm[20:0], and imm[0] = 0.
  - U: imm[11:0] = 0.
  - R: imm is ignored.
- mem_addr increments modulo 2^ADDR_W.

## Timing
- Reset values: in_ready 0 in the reset cycle, then 1. mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, count 0, err 0, err_code 0, state IDLE.
- Latency: acceptance at edge t → mem_we high from cycle t+1.
- Minimum per-word cost is 2 cycles: accept, then one cycle with mem_ack tied high.
- in_ready is low throughout WRITE and FULL; a bundle presented then is held by the source.
- rst_n low during WRITE aborts the write immediately (mem_we 0 on the next cycle) and restores the reset values.

## Configuration
- ASM_RANGE_CHECK_EN defined: range and alignment checks are active, and illegal bundles are rejected as described under Operation.
- ASM_RANGE_CHECK_EN undefined: immediates are silently truncated to the encodable bits. Only illegal fmt values (6, 7) set err with err_code 2.

## Test plan
- fmt I, opcode 0x13, rd 5, rs1 10, funct3 0, imm 10 → mem_wdata 0x00A50293 at mem_addr 0; count becomes 1 on mem_ack.
- Sequence sw (fmt S, rs2 5, rs1 3, funct3 2, imm 12), beq (fmt B, rs1 1, rs2 2, imm 8), lui (fmt U, rd 10, imm 0x12345000), jal (fmt J, rd 0, imm 16) → 0x0051A623, 0x00208463, 0x12345537, 0x0100006F at addresses 1..4. Feeding each word to the immediate generator returns the original imm.
- With the macro defined: fmt B with imm 7 → no mem_we, err 1, err_code 1. fmt I with imm 2048 → rejected the same way. fmt 6 → err_code 2. mem_addr is unchanged in all cases.
- mem_ack held low for 3 cycles during WRITE → mem_we, mem_addr, and mem_wdata stay stable and in_ready stays 0; the state advances only on the ack cycle.
- ADDR_W 2: after 4 writes → FULL with in_ready 0 and count 4; a start pulse → mem_addr 0, count 0, in_ready 1.
- rst_n low for one cycle mid-WRITE → mem_we 0 on the next cycle, and all outputs equal their reset values.
